// File: rtl/bcd2bin_seq_pkg.sv
// Shared definitions for the sequential BCD-to-binary converter.
// Holds the FSM state encoding, the default geometry and the BCD digit limit.
package bcd2bin_seq_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 14;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // True when a nibble is not a legal decimal digit.
  function automatic logic nibble_bad(input logic [3:0] nib);
    return (nib > DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_nibble_corr.sv
// Per-digit correction for reverse double-dabble.
// After a right shift a digit that reads >= 8 has absorbed a bit worth 5
// from the digit above instead of 8, so 3 is taken away to restore it.
// Ports:
//   i_nib  4-bit BCD digit after the shift
//   o_nib  corrected digit
module bcd_nibble_corr (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  assign o_nib = (i_nib >= 4'd8) ? (i_nib - 4'd3) : i_nib;

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble).
// A packed BCD value is loaded into the top of a {bcd, bin} working
// register; each SHIFT cycle shifts the whole register right by one and
// corrects every BCD digit. After BIN_W shifts the bin field holds the value.
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    conversion request, taken only while ready
//   bcd_in   packed BCD operand, MS digit in the top nibble
//   ready    high in IDLE
//   busy     high in SHIFT
//   done     one-cycle pulse when binary/bcd_err update
//   binary   converted value, held until the next accepted start
//   bcd_err  input contained a nibble above 9
module bcd2bin_seq
  import bcd2bin_seq_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      binary,
  output logic                  bcd_err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(BIN_W - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORK_W-1:0] r_work;
  logic [BIN_W-1:0]  r_binary;
  logic              r_err;

  logic [WORK_W-1:0] w_shift;
  logic [BCD_W-1:0]  w_corr_bcd;
  logic [WORK_W-1:0] w_next;
  logic              w_bad;
  logic              w_accept;

  // One iteration: shift, then correct each digit of the shifted value.
  assign w_shift = r_work >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_corr
    bcd_nibble_corr u_corr (
      .i_nib (w_shift[BIN_W + 4*g +: 4]),
      .o_nib (w_corr_bcd[4*g +: 4])
    );
  end

  assign w_next = {w_corr_bcd, w_shift[BIN_W-1:0]};

  always_comb begin
    w_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (nibble_bad(bcd_in[4*d +: 4])) w_bad = 1'b1;
    end
  end

  assign w_accept = (r_state == S_IDLE) && start;

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_binary <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_bad) begin
              r_binary <= '0;
              r_err    <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_IT) begin
            r_binary <= w_next[BIN_W-1:0];
            r_err    <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Working register is pure data; its contents only matter once loaded.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_work <= {bcd_in, {BIN_W{1'b0}}};
    end else if (r_state == S_SHIFT) begin
      r_work <= w_next;
    end
  end

  assign ready   = (r_state == S_IDLE);
  assign busy    = (r_state == S_SHIFT);
  assign done    = (r_state == S_DONE);
  assign binary  = r_binary;
  assign bcd_err = r_err;

endmodule

// File: tb/tb_bcd2bin_seq.sv
module tb_bcd2bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bcd_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [13:0] binary;
  logic        bcd_err;

  int n_vec;
  int n_bad;
  int cyc;

  bcd2bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .binary  (binary),
    .bcd_err (bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for done. lat counts the accepting
  // edge as 1. Returns sampled at the negedge of the done cycle.
  task automatic convert(input logic [15:0] b, input logic valid, output int lat);
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, {31'd0, valid});
    chk("ready_after_accept", {31'd0, ready}, 32'd0);
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, done}, 32'd1);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  initial begin
    int lat;
    int t0;
    int t1;
    logic seen;

    n_vec  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 16'h0000;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_binary", {18'd0, binary}, 32'd0);
    chk("rst_err", {31'd0, bcd_err}, 32'd0);

    // 9999: maximum legal operand
    convert(16'h9999, 1'b1, lat);
    chk("9999_lat", lat, 15);
    chk("9999_bin", {18'd0, binary}, 32'h270F);
    chk("9999_err", {31'd0, bcd_err}, 32'd0);
    chk("9999_bcdzero", {16'd0, dut.r_work[29:14]}, 32'd0);
    @(negedge clk);
    chk("9999_ready_after", {31'd0, ready}, 32'd1);
    chk("9999_done_drop", {31'd0, done}, 32'd0);

    // back-to-back 0000 then 1234
    convert(16'h0000, 1'b1, lat);
    t0 = cyc;
    chk("0000_bin", {18'd0, binary}, 32'd0);
    convert(16'h1234, 1'b1, lat);
    t1 = cyc;
    chk("1234_bin", {18'd0, binary}, 32'h4D2);
    chk("b2b_spacing", t1 - t0, 16);

    // illegal tens digit, then a legal operand clears the flag
    convert(16'h12A4, 1'b0, lat);
    chk("12A4_lat", lat, 1);
    chk("12A4_err", {31'd0, bcd_err}, 32'd1);
    chk("12A4_bin", {18'd0, binary}, 32'd0);
    convert(16'h0042, 1'b1, lat);
    chk("0042_bin", {18'd0, binary}, 32'd42);
    chk("0042_err", {31'd0, bcd_err}, 32'd0);

    // start held through busy and DONE is not taken before ready
    @(negedge clk);
    bcd_in = 16'h0500;
    start  = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bcd_in = 16'h0001;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("hold_first_lat", lat, 15);
    chk("hold_first_bin", {18'd0, binary}, 32'd500);
    chk("hold_done_notready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk("hold_idle_ready", {31'd0, ready}, 32'd1);
    chk("hold_idle_bin", {18'd0, binary}, 32'd500);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_second_busy", {31'd0, busy}, 32'd1);
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("hold_second_lat", lat, 15);
    chk("hold_second_bin", {18'd0, binary}, 32'd1);

    // reset in the middle of a conversion aborts it
    @(negedge clk);
    bcd_in = 16'h8765;
    start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_bin", {18'd0, binary}, 32'd0);
    chk("abort_err", {31'd0, bcd_err}, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {31'd0, seen}, 32'd0);
    convert(16'h0100, 1'b1, lat);
    chk("0100_lat", lat, 15);
    chk("0100_bin", {18'd0, binary}, 32'd100);

    // strided sweep against the decimal reference value
    for (int v = 0; v <= 9999; v += 41) begin
      convert(to_bcd(v), 1'b1, lat);
      chk("sweep_bin", {18'd0, binary}, v);
      chk("sweep_bcdzero", {16'd0, dut.r_work[29:14]}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
